scrolling_block: RTL and testbench

- One obstacle sprite (a Block_n or Spike_n slot) that sits upstream of the game controller.
- Holds its own horizontal position and scrolls it left by STEP pixels on each frame-update tick.
- On a draw_start handshake from the controller, sweeps its WIDTH x HEIGHT rectangle one pixel per clock, emitting x/y/colour/plot toward the VGA adapter path.
- Reports completion on draw_done, which the controller uses to advance to the next shape.

---
 rtl/game_pkg.sv | 31 +++
 rtl/rect_scanner.sv | 63 ++++++
 rtl/scrolling_block.sv | 166 ++++++++++++++++
 tb/tb_scrolling_block.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the obstacle/shape sprites feeding the game controller:
// screen geometry, palette, coordinate width and the common draw FSM states.
`default_nettype none

package game_pkg;

  localparam int COORD_W    = 11;
  localparam int SCAN_CNT_W = 6;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_e;

endpackage

`default_nettype wire

// File: rtl/rect_scanner.sv
// Raster counter for a WIDTH x HEIGHT rectangle: cnt_x runs fastest, and both
// counters wrap back to (0,0) after the last pixel.
`default_nettype none

module rect_scanner
  import game_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear_i,
  input  logic                  step_i,
  output logic [SCAN_CNT_W-1:0] cnt_x_o,
  output logic [SCAN_CNT_W-1:0] cnt_y_o,
  output logic                  last_o
);

  localparam logic [SCAN_CNT_W-1:0] X_MAX = SCAN_CNT_W'(WIDTH - 1);
  localparam logic [SCAN_CNT_W-1:0] Y_MAX = SCAN_CNT_W'(HEIGHT - 1);

  logic [SCAN_CNT_W-1:0] cnt_x_q, cnt_x_d;
  logic [SCAN_CNT_W-1:0] cnt_y_q, cnt_y_d;
  logic                  last_x;
  logic                  last_y;

  assign last_x = (cnt_x_q == X_MAX);
  assign last_y = (cnt_y_q == Y_MAX);

  always_comb begin
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (clear_i) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
    end else if (step_i) begin
      if (last_x) begin
        cnt_x_d = '0;
        cnt_y_d = last_y ? '0 : cnt_y_q + 1'b1;
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
    end else begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
    end
  end

  assign cnt_x_o = cnt_x_q;
  assign cnt_y_o = cnt_y_q;
  assign last_o  = last_x && last_y;

endmodule

`default_nettype wire

// File: rtl/scrolling_block.sv
// Scrolling obstacle sprite: drifts left on each frame tick and, on request,
// sweeps its rectangle one pixel per clock toward the VGA adapter.
`default_nettype none

module scrolling_block
  import game_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         HEIGHT   = 8,
  parameter int         START_X  = 150,
  parameter int         START_Y  = 100,
  parameter int         STEP     = 1,
  parameter int         SCREEN_W = game_pkg::SCREEN_W,
  parameter logic [2:0] COLOUR   = 3'b100
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        draw_start,
  input  logic        update_screen,
  output logic [10:0] x_out,
  output logic [10:0] y_out,
  output logic [2:0]  colour_out,
  output logic        plot,
  output logic        draw_done,
  output logic [10:0] pos_x
);

  localparam coord_t           START_X_C = COORD_W'(START_X);
  localparam coord_t           START_Y_C = COORD_W'(START_Y);
  localparam coord_t           STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W:0] CLIP_X_C  = (COORD_W + 1)'(SCREEN_W);

  draw_state_e state_q, state_d;
  coord_t      pos_x_q, pos_x_d;
  coord_t      base_x_q, base_x_d;
  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        done_q, done_d;
  logic        move_pending_q, move_pending_d;

  logic [SCAN_CNT_W-1:0] cnt_x;
  logic [SCAN_CNT_W-1:0] cnt_y;
  logic                  scan_last;
  logic                  scan_clear;
  logic                  scan_step;

  coord_t           pix_base;
  logic [COORD_W:0] pix_x_wide;
  coord_t           pix_y;
  logic             pix_visible;
  logic             move_apply;

  rect_scanner #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (scan_clear),
    .step_i  (scan_step),
    .cnt_x_o (cnt_x),
    .cnt_y_o (cnt_y),
    .last_o  (scan_last)
  );

  // The first pixel is emitted in the same cycle draw_start is accepted, so
  // the base comes straight from pos_x while still in IDLE.
  assign pix_base    = (state_q == IDLE) ? pos_x_q : base_x_q;
  assign pix_x_wide  = {1'b0, pix_base} + {{(COORD_W + 1 - SCAN_CNT_W){1'b0}}, cnt_x};
  assign pix_y       = START_Y_C + {{(COORD_W - SCAN_CNT_W){1'b0}}, cnt_y};
  assign pix_visible = (pix_x_wide < CLIP_X_C);

  always_comb begin
    state_d    = state_q;
    base_x_d   = base_x_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    done_d     = 1'b0;
    scan_clear = 1'b0;
    scan_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (draw_start) begin
          base_x_d  = pos_x_q;
          x_d       = pix_x_wide[COORD_W-1:0];
          y_d       = pix_y;
          colour_d  = COLOUR;
          plot_d    = pix_visible;
          scan_step = 1'b1;
          state_d   = scan_last ? DONE : DRAW;
        end else begin
          scan_clear = 1'b1;
        end
      end
      DRAW: begin
        x_d       = pix_x_wide[COORD_W-1:0];
        y_d       = pix_y;
        colour_d  = COLOUR;
        plot_d    = pix_visible;
        scan_step = 1'b1;
        if (scan_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Always show draw_done for at least one cycle, even if the request
        // was withdrawn mid-sweep.
        done_d = draw_start || !done_q;
        if (!draw_start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign move_apply = (state_q == IDLE) && move_pending_q;

  always_comb begin
    pos_x_d        = pos_x_q;
    move_pending_d = update_screen || (move_pending_q && !move_apply);
    if (move_apply) begin
      pos_x_d = (pos_x_q >= STEP_C) ? (pos_x_q - STEP_C) : START_X_C;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= IDLE;
      pos_x_q        <= START_X_C;
      base_x_q       <= '0;
      x_q            <= '0;
      y_q            <= '0;
      colour_q       <= '0;
      plot_q         <= 1'b0;
      done_q         <= 1'b0;
      move_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_x_q        <= pos_x_d;
      base_x_q       <= base_x_d;
      x_q            <= x_d;
      y_q            <= y_d;
      colour_q       <= colour_d;
      plot_q         <= plot_d;
      done_q         <= done_d;
      move_pending_q <= move_pending_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign draw_done  = done_q;
  assign pos_x      = pos_x_q;

endmodule

`default_nettype wire

// File: tb/tb_scrolling_block.sv
// Directed bench for scrolling_block: three instances (default, STEP=4,
// START_X=156) share clock and reset; a pixel scoreboard checks each sweep.
`default_nettype none

module tb_scrolling_block;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ds [3];
  logic        us [3];
  logic [10:0] xo [3];
  logic [10:0] yo [3];
  logic [10:0] px [3];
  logic [2:0]  co [3];
  logic        pl [3];
  logic        dn [3];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x;
    int y;
    bit p;
  } pix_t;

  pix_t sb[$];

  always #5 clock = ~clock;

  scrolling_block u0 (
    .clock(clock), .resetn(resetn), .draw_start(ds[0]), .update_screen(us[0]),
    .x_out(xo[0]), .y_out(yo[0]), .colour_out(co[0]), .plot(pl[0]),
    .draw_done(dn[0]), .pos_x(px[0])
  );

  scrolling_block #(.STEP(4)) u1 (
    .clock(clock), .resetn(resetn), .draw_start(ds[1]), .update_screen(us[1]),
    .x_out(xo[1]), .y_out(yo[1]), .colour_out(co[1]), .plot(pl[1]),
    .draw_done(dn[1]), .pos_x(px[1])
  );

  scrolling_block #(.START_X(156)) u2 (
    .clock(clock), .resetn(resetn), .draw_start(ds[2]), .update_screen(us[2]),
    .x_out(xo[2]), .y_out(yo[2]), .colour_out(co[2]), .plot(pl[2]),
    .draw_done(dn[2]), .pos_x(px[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_move(input int k);
    us[k] = 1'b1;
    step();
    us[k] = 1'b0;
    step();
  endtask

  // One full handshake on instance k. tick_at >= 0 raises update_screen for
  // three cycles from that pixel; abort_at >= 0 resets the DUTs at that pixel.
  task automatic sweep(input int k, input int base, input int tick_at,
                       input int abort_at, input int start_x, input int pos_after);
    pix_t e;
    int   pulses = 0;
    int   exp_pulses = 0;
    for (int i = 0; i < 64; i++) begin
      e.x = base + (i % 8);
      e.y = 100 + (i / 8);
      e.p = (e.x < 160);
      if (e.p) exp_pulses++;
      sb.push_back(e);
    end
    ds[k] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      e = sb.pop_front();
      chk("pix_x", 32'(xo[k]), e.x);
      chk("pix_y", 32'(yo[k]), e.y);
      chk("pix_plot", 32'(pl[k]), 32'(e.p));
      chk("pix_colour", 32'(co[k]), 32'd4);
      chk("sweep_done_low", 32'(dn[k]), 32'd0);
      if (pl[k]) pulses++;
      if (tick_at >= 0 && i == tick_at) us[k] = 1'b1;
      if (tick_at >= 0 && i == tick_at + 3) us[k] = 1'b0;
      if (abort_at >= 0 && i == abort_at) begin
        resetn = 1'b0;
        step();
        chk("abort_plot", 32'(pl[k]), 32'd0);
        chk("abort_done", 32'(dn[k]), 32'd0);
        chk("abort_pos", 32'(px[k]), start_x);
        resetn = 1'b1;
        ds[k] = 1'b0;
        us[k] = 1'b0;
        sb.delete();
        step();
        chk("abort_idle_plot", 32'(pl[k]), 32'd0);
        return;
      end
    end
    chk("sweep_pulses", pulses, exp_pulses);
    step();
    chk("done_rise", 32'(dn[k]), 32'd1);
    chk("done_plot", 32'(pl[k]), 32'd0);
    chk("pos_during", 32'(px[k]), base);
    step();
    chk("done_held", 32'(dn[k]), 32'd1);
    ds[k] = 1'b0;
    step();
    chk("done_fall", 32'(dn[k]), 32'd0);
    step();
    chk("pos_after", 32'(px[k]), pos_after);
  endtask

  initial begin
    int idle_pulses;
    for (int k = 0; k < 3; k++) begin
      ds[k] = 1'b0;
      us[k] = 1'b0;
    end

    resetn = 1'b0;
    step();
    step();
    chk("rst_pos0", 32'(px[0]), 32'd150);
    chk("rst_pos1", 32'(px[1]), 32'd150);
    chk("rst_pos2", 32'(px[2]), 32'd156);
    chk("rst_plot", 32'(pl[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_x", 32'(xo[0]), 32'd0);
    chk("rst_y", 32'(yo[0]), 32'd0);
    chk("rst_colour", 32'(co[0]), 32'd0);
    resetn = 1'b1;
    idle_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      for (int k = 0; k < 3; k++) if (pl[k]) idle_pulses++;
    end
    chk("idle_pulses", idle_pulses, 32'd0);

    sweep(0, 150, -1, -1, 150, 150);
    sweep(0, 150, 10, -1, 150, 149);
    sweep(0, 149, -1, -1, 150, 149);

    for (int i = 1; i <= 38; i++) begin
      pulse_move(1);
      if (i == 1) chk("scroll_first", 32'(px[1]), 32'd146);
      if (i == 37) chk("scroll_37", 32'(px[1]), 32'd2);
      if (i == 38) chk("scroll_wrap", 32'(px[1]), 32'd150);
    end

    sweep(2, 156, -1, -1, 156, 156);

    sweep(0, 149, -1, 20, 150, 150);
    sweep(0, 150, -1, -1, 150, 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
